// File: rtl/cp0_exc_sequencer_if.sv
// Bus between the writeback stage / CP0 and the exception entry sequencer.
// master drives pipeline and Status inputs; slave is the sequencer itself.
interface cp0_exc_sequencer_if;
  logic [4:0]  hw_int;
  logic        timer_int;
  logic [1:0]  sw_int;
  logic [7:0]  int_mask;
  logic        int_enable;
  logic        exc_level;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_bd;
  logic        wb_exc;
  logic [4:0]  wb_cause;
  logic [31:0] wb_badva;

  logic        flush;
  logic        e_enter;
  logic [4:0]  cause;
  logic [31:0] epc;
  logic [31:0] bad_va;
  logic        delay_slot;
  logic [7:0]  pending;
  logic        busy;

  modport master (
    output hw_int, timer_int, sw_int, int_mask, int_enable, exc_level,
           wb_valid, wb_pc, wb_bd, wb_exc, wb_cause, wb_badva,
    input  flush, e_enter, cause, epc, bad_va, delay_slot, pending, busy
  );

  modport slave (
    input  hw_int, timer_int, sw_int, int_mask, int_enable, exc_level,
           wb_valid, wb_pc, wb_bd, wb_exc, wb_cause, wb_badva,
    output flush, e_enter, cause, epc, bad_va, delay_slot, pending, busy
  );
endinterface

// File: rtl/cp0_exc_sequencer.sv
// CP0 exception entry sequencer: prioritise interrupts/exceptions at writeback,
// capture context, flush, pulse E_ENTER. Define CP0_INT_SYNC_EN to synchronise HW_INT.
module cp0_exc_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  cp0_exc_sequencer_if.slave bus
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CAUSE_W = 5;
  localparam int unsigned XLEN    = 32;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_ENTER  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  typedef struct packed {
    logic [CAUSE_W-1:0] cause;
    logic [XLEN-1:0]    epc;
    logic [XLEN-1:0]    bad_va;
    logic               delay_slot;
  } exc_ctx_t;

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  exc_ctx_t        ctx_q;
  logic            flush_q;
  logic            e_enter_q;
  logic            busy_q;

  logic [4:0]      hw_int_q;
  logic [7:0]      pending_c;
  logic            int_req_c;
  logic            take_c;
  logic [XLEN-1:0] epc_c;

`ifdef CP0_INT_SYNC_EN
  logic [4:0] hw_meta_q;

  // Two-flop synchroniser for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_meta_q <= '0;
      hw_int_q  <= '0;
    end else begin
      hw_meta_q <= bus.hw_int;
      hw_int_q  <= hw_meta_q;
    end
  end
`else
  assign hw_int_q = bus.hw_int;
`endif

  assign pending_c = {bus.timer_int, hw_int_q, bus.sw_int};
  assign int_req_c = (|(pending_c & bus.int_mask)) & bus.int_enable & ~bus.exc_level;
  assign take_c    = (state_q == ST_RUN) & bus.wb_valid & (bus.wb_exc | int_req_c);
  assign epc_c     = bus.wb_bd ? (bus.wb_pc - XLEN'(4)) : bus.wb_pc;

  // Sequencer FSM with registered outputs and context capture on take
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ctx_q     <= '0;
      flush_q   <= 1'b0;
      e_enter_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (take_c) begin
            state_q              <= ST_FLUSH;
            cnt_q                <= CNT_W'(FLUSH_CYCLES - 1);
            flush_q              <= 1'b1;
            busy_q               <= 1'b1;
            ctx_q.epc            <= epc_c;
            ctx_q.delay_slot     <= bus.wb_bd;
            // Synchronous exception wins; interrupts report ExcCode 0 and keep BadVA
            if (bus.wb_exc) begin
              ctx_q.cause        <= bus.wb_cause;
              ctx_q.bad_va       <= bus.wb_badva;
            end else begin
              ctx_q.cause        <= CAUSE_W'(0);
            end
          end
        end
        ST_FLUSH: begin
          if (cnt_q == CNT_W'(0)) begin
            state_q   <= ST_ENTER;
            e_enter_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q - CNT_W'(1);
          end
        end
        ST_ENTER: begin
          state_q   <= ST_SETTLE;
          e_enter_q <= 1'b0;
          flush_q   <= 1'b0;
        end
        ST_SETTLE: begin
          // Hold off re-entry until CP0 has raised EXL
          if (bus.exc_level) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          flush_q   <= 1'b0;
          e_enter_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Flush is combinational in the take cycle so writeback cannot commit
  assign bus.flush      = take_c | flush_q;
  assign bus.e_enter    = e_enter_q;
  assign bus.busy       = busy_q;
  assign bus.cause      = ctx_q.cause;
  assign bus.epc        = ctx_q.epc;
  assign bus.bad_va     = ctx_q.bad_va;
  assign bus.delay_slot = ctx_q.delay_slot;
  assign bus.pending    = pending_c;

endmodule
